// File: rtl/mc_pkg.sv
// mc_pkg: shared multicast config type, default widths and tag-match helper
package mc_pkg;
  localparam int DEF_ID_BITS = 8;
  localparam int DEF_DATA_SIZE = 8;
  typedef struct packed {
    logic [DEF_ID_BITS-1:0] mask;
    logic [DEF_ID_BITS-1:0] id;
  } mc_cfg_t;
  function automatic logic match_tag(input logic [31:0] tag, input logic [31:0] id, input logic [31:0] mask);
    return ((tag ^ id) & ~mask) == 32'd0;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-2 FIFO with occupancy count, flush and valid/ready read side
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic wr, rd;
  assign valid_o = count_q != '0;
  assign full_o = count_q == CW'(DEPTH);
  assign data_o = valid_o ? mem[rptr_q] : '0;
  assign count_o = count_q;
  // flush wins over push/pop; pointers wrap through their natural width
  always_comb begin
    wr = push_i && !full_o && !flush_i;
    rd = valid_o && pop_i && !flush_i;
    wptr_d = flush_i ? '0 : wptr_q + PW'(wr);
    rptr_d = flush_i ? '0 : rptr_q + PW'(rd);
    count_d = flush_i ? '0 : count_q + CW'(wr) - CW'(rd);
  end
  // pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
  // storage is not reset; only written entries are ever read
  always_ff @(posedge clk) begin
    if (wr) mem[wptr_q] <= data_i;
  end
endmodule

// File: rtl/multicast_rx_buffer.sv
// multicast_rx_buffer: PE-side multicast receiver with scan-loaded ID/mask and FIFO
module multicast_rx_buffer import mc_pkg::*; #(
  parameter int ID_BITS = DEF_ID_BITS,
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int DEPTH = 4,
  parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en,
  input  logic                 scan_i,
  output logic                 scan_o,
  input  logic                 ctrl_enable,
  input  logic                 ctrl_flush,
  input  logic                 cast_valid_i,
  input  logic [ID_BITS-1:0]   cast_tag_i,
  input  logic [DATA_SIZE-1:0] cast_data_i,
  output logic                 cast_ready_o,
  output logic                 pe_valid_o,
  output logic [DATA_SIZE-1:0] pe_data_o,
  input  logic                 pe_ready_i,
  output logic [CNT_BITS-1:0]  count_o,
  output logic                 hit_o
);
  logic [2*ID_BITS-1:0] cfg_q, cfg_d;
  logic active, match, full;
  assign scan_o = cfg_q[2*ID_BITS-1];
  // chain is {mask, id}; first bit in ends up as mask MSB
  always_comb cfg_d = scan_en ? {cfg_q[2*ID_BITS-2:0], scan_i} : cfg_q;
  // configuration register
  always_ff @(posedge clk) begin
    if (rst) cfg_q <= '0;
    else cfg_q <= cfg_d;
  end
  // ready depends only on tag match, never on valid, so non-targets never stall the bus
  always_comb begin
    active = ctrl_enable && !scan_en;
    match = match_tag(32'(cast_tag_i), 32'(cfg_q[ID_BITS-1:0]), 32'(cfg_q[2*ID_BITS-1:ID_BITS]));
    hit_o = active && cast_valid_i && match;
    cast_ready_o = !(active && match) || !full;
  end
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_SIZE), .CW(CNT_BITS)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush_i(ctrl_flush),
    .push_i(hit_o),
    .data_i(cast_data_i),
    .pop_i(pe_ready_i),
    .valid_o(pe_valid_o),
    .data_o(pe_data_o),
    .full_o(full),
    .count_o(count_o)
  );
endmodule

// File: tb/tb_multicast_rx_buffer.sv
// tb_multicast_rx_buffer: randomized scoreboard bench against a queue-based reference model
module tb_multicast_rx_buffer;
  logic clk = 0, rst, scan_en, scan_i, scan_o, ctrl_enable, ctrl_flush;
  logic cast_valid_i, cast_ready_o, pe_valid_o, pe_ready_i, hit_o;
  logic [7:0] cast_tag_i, cast_data_i, pe_data_o;
  logic [2:0] count_o;
  int pass = 0, total = 0;
  bit en = 1;
  bit [7:0] mq[$];
  bit [7:0] sb[$];
  bit hist[$];

  multicast_rx_buffer dut (
    .clk(clk), .rst(rst), .scan_en(scan_en), .scan_i(scan_i), .scan_o(scan_o),
    .ctrl_enable(ctrl_enable), .ctrl_flush(ctrl_flush), .cast_valid_i(cast_valid_i),
    .cast_tag_i(cast_tag_i), .cast_data_i(cast_data_i), .cast_ready_o(cast_ready_o),
    .pe_valid_o(pe_valid_o), .pe_data_o(pe_data_o), .pe_ready_i(pe_ready_i),
    .count_o(count_o), .hit_o(hit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    else pass++;
  endtask

  function automatic bit [15:0] exp_cfg();
    bit [15:0] c = 0;
    for (int i = 0; i < 16; i++) begin
      int idx = hist.size() - 16 + i;
      c = {c[14:0], idx >= 0 ? hist[idx] : 1'b0};
    end
    return c;
  endfunction

  task automatic cyc(input bit v, input bit [7:0] t, input bit [7:0] d, input bit r,
                     input bit f = 0, input bit se = 0, input bit si = 0, input bit rs = 0);
    bit [15:0] c;
    bit act, mt, pushm, popm;
    @(negedge clk);
    chk("count", 32'(count_o), mq.size());
    chk("pe_valid", 32'(pe_valid_o), 32'(mq.size() != 0));
    c = exp_cfg();
    chk("scan_o", 32'(scan_o), 32'(c[15]));
    if (mq.size() == 0) chk("pe_data_zero", 32'(pe_data_o), 0);
    cast_valid_i = v; cast_tag_i = t; cast_data_i = d; pe_ready_i = r;
    ctrl_flush = f; scan_en = se; scan_i = si; rst = rs; ctrl_enable = en;
    #1;
    act = en && !se;
    mt = ((t ^ c[7:0]) & ~c[15:8]) == 8'd0;
    chk("hit", 32'(hit_o), 32'(act && v && mt));
    chk("cast_ready", 32'(cast_ready_o), 32'(!(act && mt) || mq.size() != 4));
    if (rs) begin
      mq.delete(); sb.delete(); hist.delete();
    end else begin
      if (se) hist.push_back(si);
      if (f) begin
        mq.delete(); sb.delete();
      end else begin
        popm = mq.size() > 0 && r;
        pushm = act && v && mt && mq.size() < 4;
        if (popm) void'(mq.pop_front());
        if (pushm) begin mq.push_back(d); sb.push_back(d); end
      end
    end
  endtask

  task automatic scan_load(input bit [7:0] m, input bit [7:0] id);
    bit [15:0] v = {m, id};
    for (int i = 15; i >= 0; i--) cyc(0, 8'h00, 8'h00, 0, 0, 1, v[i]);
  endtask

  initial begin : monitor
    bit [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (pe_valid_o && pe_ready_i && !ctrl_flush && !rst) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("pe_data", 32'(pe_data_o), 32'(e));
        end
      end
    end
  end

  initial begin : stim
    bit [15:0] c;
    bit [7:0] m, id, t;
    rst = 1; scan_en = 0; scan_i = 0; ctrl_enable = 1; ctrl_flush = 0;
    cast_valid_i = 0; cast_tag_i = 0; cast_data_i = 0; pe_ready_i = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    cyc(0, 8'h00, 8'h00, 0);
    scan_load(8'h00, 8'h2A);
    cyc(1, 8'h2A, 8'h11, 1);
    cyc(1, 8'h2B, 8'h12, 1);
    cyc(0, 8'h00, 8'h00, 1);
    scan_load(8'h0F, 8'h20);
    cyc(1, 8'h25, 8'h21, 1);
    cyc(1, 8'h2F, 8'h22, 1);
    cyc(1, 8'h35, 8'h23, 1);
    cyc(0, 8'h00, 8'h00, 1);
    scan_load(8'hFF, 8'h00);
    for (int i = 0; i < 6; i++) cyc(1, 8'($urandom), 8'($urandom), 1);
    cyc(0, 8'h00, 8'h00, 1);
    cyc(0, 8'h00, 8'h00, 1);
    scan_load(8'h00, 8'h2A);
    for (int i = 1; i <= 5; i++) cyc(1, 8'h2A, 8'(i), 0);
    cyc(1, 8'h2A, 8'd5, 1);
    cyc(1, 8'h2A, 8'd5, 0);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 8'h00, 1);
    cyc(1, 8'h2A, 8'h31, 0);
    cyc(1, 8'h2A, 8'h32, 0);
    for (int i = 0; i < 10; i++) cyc(1, 8'h2A, 8'(8'h40 + i), 1);
    cyc(1, 8'h2A, 8'h50, 0);
    cyc(1, 8'h2A, 8'h51, 1, 1);
    cyc(1, 8'h2A, 8'h52, 0);
    cyc(1, 8'h2A, 8'h53, 0);
    cyc(0, 8'h00, 8'h00, 0, 0, 1, 1, 1);
    cyc(1, 8'h2A, 8'h60, 0);
    cyc(1, 8'h00, 8'h61, 0);
    cyc(1, 8'h00, 8'h62, 0);
    en = 0;
    for (int i = 0; i < 4; i++) cyc(1, 8'h00, 8'h70, 1);
    en = 1;
    for (int r = 0; r < 20; r++) begin
      m = ($urandom_range(2) == 0) ? 8'h00 : ($urandom_range(1) == 0) ? 8'h0F : 8'($urandom);
      id = 8'($urandom);
      scan_load(m, id);
      for (int i = 0; i < 30; i++) begin
        c = exp_cfg();
        t = ($urandom_range(1) == 0) ? ((c[7:0] & ~c[15:8]) | (8'($urandom) & c[15:8])) : 8'($urandom);
        en = $urandom_range(7) != 0;
        cyc(1'($urandom), t, 8'($urandom), 1'($urandom), $urandom_range(31) == 0);
      end
    end
    en = 1;
    for (int i = 0; i < 6; i++) cyc(0, 8'h00, 8'h00, 1);
    @(negedge clk);
    #3;
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
